// File: rtl/pipe_controller.sv
// pipe_controller: pipelined MIPS main/ALU controller.
// Decodes opD/functD combinationally in the Decode stage, then carries the
// resulting control word through E, M and W pipeline registers. stallE holds
// the E register and injects a bubble into M. flushE clears E. Reset is
// synchronous and active-high.
//
// Parameters:
//   ALUCTRL_W  width of alucontrolE (>= 3); the upper bits are always 0
//   EXT_OPS    1: bne/andi/ori decoded; 0: they decode as illegal
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   opD, functD                   opcode/funct of the instruction in Decode
//   stallE, flushE                hazard-unit controls for the E register
//   branchD, bneD, jumpD,
//   signextD, illegalD            combinational Decode-stage controls
//   regwriteE .. alucontrolE      E-stage controls
//   regwriteM, memtoregM,
//   memwriteM                     M-stage controls
//   regwriteW, memtoregW          W-stage controls
module pipe_controller #(
    parameter int unsigned ALUCTRL_W = 3,
    parameter bit          EXT_OPS   = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           opD,
    input  logic [5:0]           functD,
    input  logic                 stallE,
    input  logic                 flushE,
    output logic                 branchD,
    output logic                 bneD,
    output logic                 jumpD,
    output logic                 signextD,
    output logic                 illegalD,
    output logic                 regwriteE,
    output logic                 memtoregE,
    output logic                 memwriteE,
    output logic                 alusrcE,
    output logic                 regdstE,
    output logic [ALUCTRL_W-1:0] alucontrolE,
    output logic                 regwriteM,
    output logic                 memtoregM,
    output logic                 memwriteM,
    output logic                 regwriteW,
    output logic                 memtoregW
);

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpJ     = 6'b000010;

    localparam logic [5:0] FnNop = 6'b000000;
    localparam logic [5:0] FnAdd = 6'b100000;
    localparam logic [5:0] FnSub = 6'b100010;
    localparam logic [5:0] FnAnd = 6'b100100;
    localparam logic [5:0] FnOr  = 6'b100101;
    localparam logic [5:0] FnSlt = 6'b101010;

    localparam logic [2:0] AluAdd = 3'b010;
    localparam logic [2:0] AluSub = 3'b110;
    localparam logic [2:0] AluAnd = 3'b000;
    localparam logic [2:0] AluOr  = 3'b001;
    localparam logic [2:0] AluSlt = 3'b111;

    typedef struct packed {
        logic       regwrite;
        logic       memtoreg;
        logic       memwrite;
        logic       alusrc;
        logic       regdst;
        logic [2:0] alu;
    } ctrl_e_t;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
        logic memwrite;
    } ctrl_m_t;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
    } ctrl_w_t;

    ctrl_e_t dec_word;
    ctrl_e_t e_q;
    ctrl_m_t m_q;
    ctrl_w_t w_q;

    // Decode. Every path that flags illegalD leaves the rest of the word at 0,
    // so an illegal instruction enters E as a NOP.
    always_comb begin
        branchD  = 1'b0;
        bneD     = 1'b0;
        jumpD    = 1'b0;
        signextD = 1'b0;
        illegalD = 1'b0;
        dec_word = '0;
        unique case (opD)
            OpRtype: begin
                if (functD != FnNop) begin
                    dec_word.regwrite = 1'b1;
                    dec_word.regdst   = 1'b1;
                    signextD          = 1'b1;
                    case (functD)
                        FnAdd:   dec_word.alu = AluAdd;
                        FnSub:   dec_word.alu = AluSub;
                        FnAnd:   dec_word.alu = AluAnd;
                        FnOr:    dec_word.alu = AluOr;
                        FnSlt:   dec_word.alu = AluSlt;
                        default: begin
                            dec_word = '0;
                            signextD = 1'b0;
                            illegalD = 1'b1;
                        end
                    endcase
                end
            end
            OpLw: begin
                dec_word.regwrite = 1'b1;
                dec_word.alusrc   = 1'b1;
                dec_word.memtoreg = 1'b1;
                dec_word.alu      = AluAdd;
                signextD          = 1'b1;
            end
            OpSw: begin
                dec_word.memwrite = 1'b1;
                dec_word.alusrc   = 1'b1;
                dec_word.alu      = AluAdd;
                signextD          = 1'b1;
            end
            OpBeq: begin
                branchD      = 1'b1;
                signextD     = 1'b1;
                dec_word.alu = AluSub;
            end
            OpBne: begin
                if (EXT_OPS) begin
                    branchD      = 1'b1;
                    bneD         = 1'b1;
                    signextD     = 1'b1;
                    dec_word.alu = AluSub;
                end else begin
                    illegalD = 1'b1;
                end
            end
            OpAddi: begin
                dec_word.regwrite = 1'b1;
                dec_word.alusrc   = 1'b1;
                dec_word.alu      = AluAdd;
                signextD          = 1'b1;
            end
            OpAndi, OpOri: begin
                // Logical immediates are zero-extended.
                if (EXT_OPS) begin
                    dec_word.regwrite = 1'b1;
                    dec_word.alusrc   = 1'b1;
                    dec_word.alu      = (opD == OpOri) ? AluOr : AluAnd;
                end else begin
                    illegalD = 1'b1;
                end
            end
            OpJ: begin
                jumpD = 1'b1;
            end
            default: begin
                illegalD = 1'b1;
            end
        endcase
    end

    // Pipeline registers. M takes the old E word unless E is stalled, in which
    // case a bubble goes down while E keeps its instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            if (flushE) begin
                e_q <= '0;
            end else if (!stallE) begin
                e_q <= dec_word;
            end
            if (stallE) begin
                m_q <= '0;
            end else begin
                m_q <= '{regwrite: e_q.regwrite, memtoreg: e_q.memtoreg,
                         memwrite: e_q.memwrite};
            end
            w_q <= '{regwrite: m_q.regwrite, memtoreg: m_q.memtoreg};
        end
    end

    assign regwriteE   = e_q.regwrite;
    assign memtoregE   = e_q.memtoreg;
    assign memwriteE   = e_q.memwrite;
    assign alusrcE     = e_q.alusrc;
    assign regdstE     = e_q.regdst;
    assign alucontrolE = ALUCTRL_W'(e_q.alu);
    assign regwriteM   = m_q.regwrite;
    assign memtoregM   = m_q.memtoreg;
    assign memwriteM   = m_q.memwrite;
    assign regwriteW   = w_q.regwrite;
    assign memtoregW   = w_q.memtoreg;

endmodule

// File: doc/pipe_controller.md
# pipe_controller

Pipelined successor to the single-cycle MIPS controller: decodes `op`/`funct` in the Decode stage and carries the control word through E, M and W pipeline registers in step with the datapath. Adds stall and flush handling for hazard-unit hookup, an opcode-set extension switch, a parametrised ALU-control width, and an illegal-instruction flag. It sits beside the pipelined datapath, driven by the hazard unit.

## Interface
- `ALUCTRL_W`, 3: width of ALU control bus (≥3); codes zero-extended in upper bits.
- `EXT_OPS`, 1: 1 enables `bne`/`andi`/`ori`; 0 treats them as illegal.
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `opD`  in  6  opcode of instruction in Decode.
- `functD`  in  6  funct field of instruction in Decode.
- `stallE`  in  1  hold E register; bubble into M.
- `flushE`  in  1  load bubble into E register.
- `branchD`, `bneD`, `jumpD`, `signextD`, `illegalD`  out  1 each  combinational Decode-stage controls.
- `regwriteE`, `memtoregE`, `memwriteE`, `alusrcE`, `regdstE`  out  1 each  E-stage controls.
- `alucontrolE`  out  ALUCTRL_W  E-stage ALU operation.
- `regwriteM`, `memtoregM`, `memwriteM`  out  1 each  M-stage controls.
- `regwriteW`, `memtoregW`  out  1 each  W-stage controls.

## Operation
- ALU codes: add 010, sub 110, and 000, or 001, slt 111.
- Decode (op → regwrite, regdst, alusrc, memtoreg, memwrite, branch, bne, jump, signext, alu):
  - 000000 R-type: regwrite, regdst, signext=1; funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - R-type with functD=000000 is NOP: all controls 0, illegalD=0. Any other funct: illegal.
  - 100011 lw: regwrite, alusrc, memtoreg, signext, add.
  - 101011 sw: memwrite, alusrc, signext, add.
  - 000100 beq: branch, signext, sub. 000101 bne (EXT_OPS): branch, bne, signext, sub.
  - 001000 addi: regwrite, alusrc, signext, add.
  - 001100 andi / 001101 ori (EXT_OPS): regwrite, alusrc, signext=0, and / or.
  - 000010 j: jump only.
  - Any other opcode: illegalD=1.
- An illegal instruction drives every control (D-stage and the word entering E) to 0 except illegalD; it never writes registers or memory.
- Pipeline registers E→M→W advance every cycle unless modified below.
- Priority per cycle: `rst` > `flushE` > `stallE` > normal advance.
  - flushE: E register loads all-zero word. M loads the old E contents normally.
  - stallE (no flush): E register holds; M register loads all-zero (bubble). W advances from M.
  - flushE and stallE together: E cleared, M bubbles.
- No stall/flush inputs for M or W; they always advance.

## Timing
- D-stage outputs: purely combinational from opD/functD, zero latency, independent of `rst`.
- E outputs valid one cycle after the instruction is in D; M two cycles; W three.
- On a clock edge with `rst`=1: every E/M/W output becomes 0 (alucontrolE = 0). Reset mid-stream discards all in-flight control words; first valid E word appears one edge after rst deasserts.
- All-zero word equals NOP; a bubble is indistinguishable from a NOP downstream.
- ALUCTRL_W > 3: bits [ALUCTRL_W-1:3] of alucontrolE always 0.

## Test plan
- Reset: hold rst 2 cycles with lw in D -> all E/M/W outputs 0; release -> regwriteE=1, memtoregE=1, alusrcE=1, alucontrolE=010 next edge; regwriteW=1 three edges later.
- R-type sweep: op 000000, funct add/sub/and/or/slt on consecutive cycles -> alucontrolE 010,110,000,001,111 one cycle later; funct 000000 -> all zeros, illegalD=0; funct 001000 -> illegalD=1, all zeros.
- Load-use: lw then add with stallE=1 for one cycle -> E holds add word, memtoregM=0/regwriteM=0 bubble for that cycle, add reaches W exactly one cycle late.
- Flush: beq in D, flushE=1 on the edge -> E all zeros next cycle while branchD=1, signextD=1 combinationally; flushE+stallE together -> E and M both zero.
- EXT_OPS=0 vs 1: ori (001101) -> EXT_OPS=1: regwriteE=1, alucontrolE=001, signextD=0; EXT_OPS=0: illegalD=1, regwriteE=0. bne -> bneD=1 only when EXT_OPS=1.
- ALUCTRL_W=4: slt -> alucontrolE=0111; sw -> memwriteM=1 two edges after D, regwriteM=0.
